// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two NBYTES-byte operands through one shared external
// 8-bit adder. It works one byte per cycle, least significant byte first, and
// chains the carry from each byte into the next.
module wide_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
  input  logic                in_cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_sum,
  output logic                out_cout,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_sum,
  input  logic                add_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          carry_q, carry_d, cout_q, cout_d, valid_q, valid_d;
  logic [7:0]    a_byte, b_byte;

  // Current operand bytes, chosen by the byte index. A shift keeps the select in range for any index.
  assign a_byte = 8'(a_q >> {idx_q, 3'b000});
  assign b_byte = 8'(b_q >> {idx_q, 3'b000});

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

  // Next-state logic, adder drive and handshake outputs. The adder inputs stay at zero outside RUN.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    valid_d   = valid_q;
    in_ready  = 1'b0;
    add_a     = 8'h00;
    add_b     = 8'h00;
    add_cin   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_byte;
        add_b   = b_byte;
        add_cin = carry_q;
        for (int k = 0; k < NBYTES; k++)
          if (idx_q == IW'(k)) sum_d[8*k +: 8] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = add_cout;
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset aborts any operation in flight and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer. It builds an NBYTES=4 instance and an NBYTES=1
// instance, each driving its own ideal 8-bit adder. Results are checked against
// plain wide arithmetic.
module tb_wide_add_sequencer;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid4 = 1'b0, in_valid1 = 1'b0, out_ready = 1'b0, in_cin = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  int          tests = 0, fails = 0, cyc = 0;
  bit          sel1 = 1'b0;

  logic        in_ready4, out_valid4, out_cout4, add_cin4, add_cout4;
  logic [31:0] out_sum4;
  logic [7:0]  add_a4, add_b4, add_sum4;
  logic        in_ready1, out_valid1, out_cout1, add_cin1, add_cout1;
  logic [7:0]  out_sum1, add_a1, add_b1, add_sum1;

  // Ideal external adders.
  assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + 9'(add_cin4);
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + 9'(add_cin1);

  wide_add_sequencer #(.NBYTES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid4),
    .out_ready(out_ready), .out_sum(out_sum4), .out_cout(out_cout4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_sum(add_sum4), .add_cout(add_cout4));

  wide_add_sequencer #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin), .out_valid(out_valid1),
    .out_ready(out_ready), .out_sum(out_sum1), .out_cout(out_cout1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1));

  // Outputs of whichever instance is under test.
  logic        ov, ir, oc, acin;
  logic [31:0] os;
  logic [7:0]  aa, ab;
  assign ov   = sel1 ? out_valid1 : out_valid4;
  assign ir   = sel1 ? in_ready1  : in_ready4;
  assign oc   = sel1 ? out_cout1  : out_cout4;
  assign os   = sel1 ? {24'h0, out_sum1} : out_sum4;
  assign aa   = sel1 ? add_a1 : add_a4;
  assign ab   = sel1 ? add_b1 : add_b4;
  assign acin = sel1 ? add_cin1 : add_cin4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation on the selected instance. Call it at posedge+1 with the
  // instance idle. Before the handshake, out_ready is held low for `hold` DONE
  // cycles while junk operands are offered. keep_rdy leaves out_ready high afterwards.
  task automatic do_op(input bit one, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input int hold, input bit keep_rdy,
                       output int acc_cyc);
    int          nb;
    logic [32:0] full;
    logic [31:0] es;
    logic        ec;
    nb   = one ? 1 : 4;
    full = one ? 33'({1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(c))
               : {1'b0, a} + {1'b0, b} + 33'(c);
    es   = one ? {24'h0, full[7:0]} : full[31:0];
    ec   = one ? full[8] : full[32];
    sel1 = one;
    #0;
    chk("idle_in_ready", 64'(ir), 64'd1);
    chk("idle_add_zero", {aa, ab, 7'd0, acin}, 64'd0);
    if (one) in_valid1 = 1'b1; else in_valid4 = 1'b1;
    in_a = a; in_b = b; in_cin = c;
    tick();
    acc_cyc = cyc;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    #0;
    chk("run_byte0_a", 64'(aa), 64'(a[7:0]));
    chk("run_byte0_cin", 64'(acin), 64'(c));
    in_a = $urandom; in_b = $urandom; in_cin = ~c;
    chk("run_in_ready", 64'(ir), 64'd0);
    repeat (nb) begin
      chk("run_no_valid", 64'(ov), 64'd0);
      tick();
    end
    chk("done_valid", 64'(ov), 64'd1);
    chk("done_sum", 64'(os), 64'(es));
    chk("done_cout", 64'(oc), 64'(ec));
    chk("done_add_zero", {aa, ab, 7'd0, acin}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (one) in_valid1 = 1'b1; else in_valid4 = 1'b1;
      in_a = $urandom; in_b = $urandom;
      tick();
      chk("hold_valid", 64'(ov), 64'd1);
      chk("hold_sum", 64'(os), 64'(es));
      chk("hold_cout", 64'(oc), 64'(ec));
      chk("hold_in_ready", 64'(ir), 64'd0);
    end
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hs_valid_low", 64'(ov), 64'd0);
    chk("hs_in_ready", 64'(ir), 64'd1);
    chk("hs_sum_kept", 64'(os), 64'(es));
    if (!keep_rdy) out_ready = 1'b0;
  endtask

  initial begin
    int acc, prev;
    logic [31:0] ra, rb;
    // Reset state
    #12;
    chk("rst_valid4", 64'(out_valid4), 64'd0);
    chk("rst_sum4", 64'(out_sum4), 64'd0);
    chk("rst_cout4", 64'(out_cout4), 64'd0);
    chk("rst_ready4", 64'(in_ready4), 64'd1);
    chk("rst_valid1", 64'(out_valid1), 64'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Directed cases from the datasheet examples
    do_op(0, 32'h000000FF, 32'h00000001, 1'b0, 0, 0, acc);
    do_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 0, 0, acc);
    do_op(0, 32'hDEADBEEF, 32'h01234567, 1'b0, 3, 0, acc);

    // Reset after two RUN cycles
    sel1 = 1'b0;
    in_valid4 = 1'b1; in_a = 32'hA5A5A5A5; in_b = 32'h5A5A5A5A; in_cin = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick(); tick();
    chk("pre_rst_add_a", 64'(add_a4), 64'h00A5);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid4), 64'd0);
    chk("mid_rst_add", {add_a4, add_b4, 7'd0, add_cin4}, 64'd0);
    chk("mid_rst_ready", 64'(in_ready4), 64'd1);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("post_rst_valid", 64'(out_valid4), 64'd0);
    do_op(0, 32'h12345678, 32'h00000001, 1'b0, 0, 0, acc);

    // Back-to-back with out_ready held high: one accept every NBYTES+2 cycles
    out_ready = 1'b1;
    do_op(0, 32'h11111111, 32'h22222222, 1'b0, 0, 1, prev);
    for (int i = 0; i < 3; i++) begin
      do_op(0, $urandom, $urandom, 1'(i), 0, 1, acc);
      chk("b2b_spacing", 64'(acc - prev), 64'd6);
      prev = acc;
    end
    out_ready = 1'b0;

    // Random operations on the 4-byte instance
    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom;
      if (i == 0) begin ra = 32'hFFFFFFFF; rb = 32'hFFFFFFFF; end
      do_op(0, ra, rb, 1'($urandom_range(1)), int'($urandom_range(2)), 0, acc);
    end

    // Single-byte instance
    do_op(1, 32'h07, 32'h02, 1'b1, 0, 0, acc);
    do_op(1, 32'h80, 32'h80, 1'b0, 2, 0, acc);
    out_ready = 1'b1;
    do_op(1, 32'hF0, 32'h0F, 1'b1, 0, 1, prev);
    do_op(1, 32'h55, 32'h22, 1'b0, 0, 1, acc);
    chk("b2b_spacing_n1", 64'(acc - prev), 64'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      do_op(1, $urandom, $urandom, 1'($urandom_range(1)), int'($urandom_range(1)), 0, acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
